bram_port_req_ctrl: RTL

//  Request/response front-end for one port of the true-dual-port read-first block RAM (bram_tdp_rf_rf).

---
 rtl/hir_bram_pkg.sv | 18 +
 rtl/hir_sync_fifo.sv | 71 +++++++
 rtl/bram_port_req_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/hir_bram_pkg.sv
`default_nettype none
// ============================================================================
// hir_bram_pkg
//   Shared constants and helpers for the block-RAM port front-ends.
//   Rev 1.0 - initial release
// ============================================================================
package hir_bram_pkg;

    // Read latency of the attached RAM: data appears one edge after en.
    localparam int RD_LATENCY = 1;

    // Word-address width for a RAM of the given depth (at least one bit).
    function automatic int addr_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hir_sync_fifo.sv
`default_nettype none
// ============================================================================
// hir_sync_fifo
//   Single-clock FIFO, power-of-2 depth, head entry read straight from the
//   storage registers so the output is stable while not popped.
//   Rev 1.0 - initial release
// ============================================================================
module hir_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one = 1;
    localparam logic [c_ptr_w:0]   c_cnt_one = 1;
    localparam logic [c_ptr_w:0]   c_cnt_max = DEPTH;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // Storage is protected against overflow/underflow even if the caller misbehaves.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    assign full  = (r_count == c_cnt_max);
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rd_ptr];

    // Data storage: no reset, contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally modulo DEPTH; occupancy tracks push minus pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_port_req_ctrl.sv
`default_nettype none
// ============================================================================
// bram_port_req_ctrl
//   Valid/ready request front-end for one port of a read-first block RAM.
//   Drives en/we/addr/di directly from accepted requests, captures read data
//   into a response FIFO, and credit-limits reads so the FIFO cannot overflow.
//   Rev 1.0 - initial release
// ============================================================================
module bram_port_req_ctrl
    import hir_bram_pkg::*;
#(
    parameter int SIZE      = 1024,
    parameter int WIDTH     = 256,
    parameter int RSP_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [addr_width(SIZE)-1:0] req_addr,
    input  logic [WIDTH-1:0]            req_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [WIDTH-1:0]            rsp_data,
    output logic                        bram_en,
    output logic                        bram_we,
    output logic [addr_width(SIZE)-1:0] bram_addr,
    output logic [WIDTH-1:0]            bram_di,
    input  logic [WIDTH-1:0]            bram_do
);

    localparam int                  c_pend_w   = $clog2(RSP_DEPTH) + 1;
    localparam logic [c_pend_w-1:0] c_pend_max = RSP_DEPTH;
    localparam logic [c_pend_w-1:0] c_pend_one = 1;

    logic [c_pend_w-1:0]   r_pending;
    logic [RD_LATENCY-1:0] r_rd_pipe;
    logic                  w_accept;
    logic                  w_rd_accept;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;

    // Ready depends only on the credit register (and reset), never on this cycle's request.
    assign req_ready   = rst_n && (r_pending < c_pend_max);
    assign w_accept    = req_valid && req_ready;
    assign w_rd_accept = w_accept && !req_we;

    assign bram_en   = w_accept;
    assign bram_we   = w_accept && req_we;
    assign bram_addr = req_addr;
    assign bram_di   = req_data;

    assign rsp_valid = rst_n && !w_fifo_empty;
    assign w_pop     = rsp_valid && rsp_ready;
    assign w_push    = r_rd_pipe[RD_LATENCY-1];

    // Credit counter: reads accepted but not yet handed to the consumer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else if (w_rd_accept && !w_pop) begin
            r_pending <= r_pending + c_pend_one;
        end else if (w_pop && !w_rd_accept) begin
            r_pending <= r_pending - c_pend_one;
        end
    end

    // Tracks reads travelling through the RAM so their data is captured on arrival.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_pipe <= '0;
        end else begin
            r_rd_pipe[0] <= w_rd_accept;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
        end
    end

    // Credits bound FIFO occupancy, so a push into a full FIFO means broken accounting.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_push && w_fifo_full))
                else $error("response FIFO push while full");
        end
    end

    hir_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (bram_do),
        .pop   (w_pop),
        .dout  (rsp_data),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

endmodule
`default_nettype wire
